// File: rtl/btn_input_port.sv
// Push-button input port: synchronise, debounce, latch press events,
// expose them to the CPU with a clear-on-read strobe and a level IRQ.
//
// Ports:
//   CLK        CPU clock
//   RESET_N    async active-low reset
//   BTN_IN     raw active-low button pins (asynchronous to CLK)
//   RD         one-cycle read strobe
//   RD_DATA    {PRESS_PEND, BTN_STATE} captured on RD
//   BTN_STATE  debounced state, 1 = pressed
//   PRESS_PEND sticky press-event flags
//   IRQ        registered OR of PRESS_PEND
module btn_input_port #(
    parameter int N        = 4,
    parameter int DEBOUNCE = 50000
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [N-1:0]   BTN_IN,
    input  logic           RD,
    output logic [2*N-1:0] RD_DATA,
    output logic [N-1:0]   BTN_STATE,
    output logic [N-1:0]   PRESS_PEND,
    output logic           IRQ
);

    localparam int CNT_W = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [N-1:0]     r_sync1;
    logic [N-1:0]     r_sync2;
    logic [CNT_W-1:0] r_cnt [N];
    logic [N-1:0]     r_state;
    logic [N-1:0]     r_prev;
    logic [N-1:0]     r_pend;
    logic             r_irq;
    logic [2*N-1:0]   r_rd_data;

    logic [N-1:0]     w_s;
    logic [N-1:0]     w_press;
    logic [N-1:0]     w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [N];
    logic [N-1:0]     w_pend_nxt;

    // Pins are active-low; flip after synchronising so s is 1 = pressed
    assign w_s     = ~r_sync2;
    assign w_press = r_state & ~r_prev;

    // Per-bit debounce: count consecutive cycles of disagreement,
    // any return to agreement restarts the count.
    always_comb begin
        w_state_nxt = r_state;
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_s[i] != r_state[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_state_nxt[i] = w_s[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A read clears what was pending but keeps a press landing this cycle
    always_comb begin
        if (RD) begin
            w_pend_nxt = w_press;
        end else begin
            w_pend_nxt = r_pend | w_press;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
            r_state   <= '0;
            r_prev    <= '0;
            r_pend    <= '0;
            r_irq     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_sync1 <= BTN_IN;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_state <= w_state_nxt;
            r_prev  <= r_state;
            r_pend  <= w_pend_nxt;
            r_irq   <= |r_pend;
            if (RD) begin
                r_rd_data <= {r_pend, r_state};
            end
        end
    end

    assign RD_DATA    = r_rd_data;
    assign BTN_STATE  = r_state;
    assign PRESS_PEND = r_pend;
    assign IRQ        = r_irq;

endmodule

// File: tb/tb_btn_input_port.sv
// Self-checking bench for btn_input_port (N=4, DEBOUNCE=4) against a
// history-based reference model of the debounce and press/read rules.
module tb_btn_input_port;

    localparam int N = 4;
    localparam int D = 4;
    localparam int HMAX = 8192;

    logic           CLK;
    logic           RESET_N;
    logic [N-1:0]   BTN_IN;
    logic           RD;
    logic [2*N-1:0] RD_DATA;
    logic [N-1:0]   BTN_STATE;
    logic [N-1:0]   PRESS_PEND;
    logic           IRQ;

    btn_input_port #(.N(N), .DEBOUNCE(D)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .BTN_IN     (BTN_IN),
        .RD         (RD),
        .RD_DATA    (RD_DATA),
        .BTN_STATE  (BTN_STATE),
        .PRESS_PEND (PRESS_PEND),
        .IRQ        (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. s seen at edge k is the inverted pin sampled two
    // edges earlier; a bit flips at edge k when s disagreed with it on
    // each of the last D edges and no flip/reset lies inside that window.
    logic [N-1:0]   m_state, m_prev, m_pend, pa, pb;
    logic           m_irq;
    logic [2*N-1:0] m_rd;
    logic [N-1:0]   shist [0:HMAX-1];
    int             last_flip [N];
    int             k;

    task automatic model_reset();
        m_state = '0; m_prev = '0; m_pend = '0;
        m_irq = 1'b0; m_rd = '0;
        pa = '1; pb = '1; k = 0;
        for (int i = 0; i < N; i++) last_flip[i] = 0;
    endtask

    task automatic tick();
        logic [N-1:0] pin, nstate, press;
        logic         rd;
        bit           all_diff;
        pin = BTN_IN;
        rd  = RD;
        @(posedge CLK);
        k++;
        if (k >= HMAX) begin
            $display("FAIL history overflow");
            $fatal(1);
        end
        shist[k] = ~pb;
        pb = pa;
        pa = pin;
        nstate = m_state;
        for (int i = 0; i < N; i++) begin
            if (k - last_flip[i] >= D) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (shist[k-j][i] == m_state[i]) all_diff = 1'b0;
                if (all_diff) begin
                    nstate[i] = ~m_state[i];
                    last_flip[i] = k;
                end
            end
        end
        press = m_state & ~m_prev;
        if (rd) m_rd = {m_pend, m_state};
        m_irq  = |m_pend;
        m_pend = rd ? press : (m_pend | press);
        m_prev  = m_state;
        m_state = nstate;
        #1;
        check("state", BTN_STATE, m_state);
        check("pend", PRESS_PEND, m_pend);
        check("irq", IRQ, m_irq);
        check("rd_data", RD_DATA, m_rd);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RESET_N = 1'b0;
        BTN_IN  = 4'b0000;
        RD      = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_state", BTN_STATE, 0);
        check("rst_pend", PRESS_PEND, 0);
        check("rst_irq", IRQ, 0);
        check("rst_rd", RD_DATA, 0);
        model_reset();
        RESET_N = 1'b1;

        // Pins held pressed through reset release
        ticks(5);
        check("p1_state5", BTN_STATE, 4'h0);
        tick();
        check("p1_state6", BTN_STATE, 4'hF);
        tick();
        check("p1_pend7", PRESS_PEND, 4'hF);
        tick();
        check("p1_irq8", IRQ, 1);

        // Clear, release all, clear again
        RD = 1'b1; tick(); RD = 1'b0;
        BTN_IN = 4'hF; ticks(10);
        RD = 1'b1; tick(); RD = 1'b0; ticks(3);

        // Clean press and release on bit 0
        BTN_IN = 4'b1110; ticks(10);
        BTN_IN = 4'b1111; ticks(10);

        // Bounce on bit 1
        for (int r = 0; r < 5; r++) begin
            BTN_IN[1] = 1'b0; ticks(3);
            BTN_IN[1] = 1'b1; tick();
        end
        check("p3_nochange", BTN_STATE[1], 0);
        BTN_IN[1] = 1'b0;
        ticks(5);
        check("p3_state5", BTN_STATE[1], 0);
        tick();
        check("p3_state6", BTN_STATE[1], 1);
        ticks(3);

        // Read while a press on bit 2 reaches its press cycle
        RD = 1'b1; tick(); RD = 1'b0;
        BTN_IN[2] = 1'b0;
        ticks(6);
        RD = 1'b1; tick(); RD = 1'b0;
        check("p5_pend", PRESS_PEND[2], 1);
        RD = 1'b1; tick(); tick(); RD = 1'b0;
        ticks(2);
        check("p4_irq", IRQ, 0);

        // Randomised pins and reads
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) BTN_IN[i] = ~BTN_IN[i];
            RD = ($urandom_range(0, 5) == 0);
            tick();
        end
        RD = 1'b0;

        // Async reset mid-debounce with a pend bit set
        BTN_IN = 4'hF; ticks(10);
        BTN_IN = 4'b1110; ticks(6);
        BTN_IN = 4'b0110; ticks(4);
        #1;
        RESET_N = 1'b0;
        #1;
        check("ar_state", BTN_STATE, 0);
        check("ar_pend", PRESS_PEND, 0);
        check("ar_irq", IRQ, 0);
        check("ar_rd", RD_DATA, 0);
        model_reset();
        #1;
        RESET_N = 1'b1;
        BTN_IN = 4'b1110;
        ticks(5);
        check("ar_state5", BTN_STATE, 4'h0);
        tick();
        check("ar_state6", BTN_STATE, 4'h1);
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_input_port.md
Name: btn_input_port

Overview:
CPU-facing input port for push-buttons, the read-side counterpart to the LED output port.
- Synchronises N raw active-low button pins into the CPU clock domain.
- Debounces each bit independently.
- Latches press events in sticky pending bits.
- Gives the CPU a registered read strobe with clear-on-read and a level interrupt.
- Sits beside mcpu on the CLK_CPU domain and is reset by the same power-on reset.

Parameters:
N, 4, number of button inputs.
DEBOUNCE, 50000, cycles a synchronised input must stay different from the debounced state before that state flips; legal range ≥ 2.
CNT_W, $clog2(DEBOUNCE)+1, derived localparam, width of each per-bit counter. Not overridable.

Ports:
CLK  in  1  CPU clock (CLK_CPU domain).
RESET_N  in  1  asynchronous, active-low reset.
BTN_IN  in  N  raw button pins, active-low (0 = pressed), asynchronous to CLK.
RD  in  1  read strobe from CPU, one cycle per read.
RD_DATA  out  2N  {PRESS_PEND, BTN_STATE} captured on RD, valid the cycle after RD.
BTN_STATE  out  N  debounced state, active-high (1 = pressed).
PRESS_PEND  out  N  sticky press-event flags.
IRQ  out  1  registered OR of PRESS_PEND.

Behaviour:
- Reset (async assert on RESET_N=0, sync deassert is the caller's job):
  - sync flops = all 1 (released).
  - counters = 0.
  - BTN_STATE = 0, PRESS_PEND = 0, IRQ = 0, RD_DATA = 0.
- Synchroniser:
  - two flops per bit on BTN_IN.
  - s = inverted output of the second flop, so s is active-high.
- Debounce, per bit i, evaluated every clock:
  - s[i]==BTN_STATE[i]: cnt[i] <= 0.
  - s[i]!=BTN_STATE[i] and cnt[i] < DEBOUNCE-1: cnt[i] <= cnt[i]+1.
  - s[i]!=BTN_STATE[i] and cnt[i]==DEBOUNCE-1: BTN_STATE[i] <= s[i]; cnt[i] <= 0.
  - Net effect: BTN_STATE flips exactly DEBOUNCE cycles after s first differs, provided s holds.
  - Any glitch back to agreement restarts the count from 0.
- Latency:
  - raw pin edge to BTN_STATE change = 2 + DEBOUNCE cycles.
  - BTN_STATE rise to PRESS_PEND set = +1 cycle.
  - PRESS_PEND to IRQ = +1 cycle.
- Press detection:
  - press[i] = BTN_STATE[i] & ~prev[i], where prev is BTN_STATE delayed one cycle.
  - Releases generate no event.
- Read handshake:
  - On a cycle with RD=1: RD_DATA <= {PRESS_PEND, BTN_STATE}.
  - On the same edge: PRESS_PEND <= press (bits pending before the read are cleared; a press arriving on the read cycle survives).
  - Without RD: PRESS_PEND <= PRESS_PEND | press.
  - RD_DATA holds its last value when RD=0.
  - Back-to-back RD is legal: the second read returns the post-clear pend bits.
- IRQ:
  - IRQ <= |PRESS_PEND (one register stage).
  - IRQ stays high until a read clears all pend bits and no new press arrives.
- Reset mid-debounce or while pend is set: everything returns to reset values immediately, with no event generated.
- Counter width: cnt never exceeds DEBOUNCE-1; no wrap-around possible.

Test Plan (DEBOUNCE=4, N=4):
1. Reset: hold RESET_N=0 with BTN_IN=4'b0000 → BTN_STATE=0, PRESS_PEND=0, IRQ=0. After release with the pins held, BTN_STATE=4'b1111 at exactly cycle 6, PRESS_PEND=4'b1111 at cycle 7, IRQ=1 at cycle 8.
2. Clean press: BTN_IN[0] 1→0 at cycle t → BTN_STATE[0]=1 at t+6, PRESS_PEND[0]=1 at t+7, IRQ=1 at t+8. Release gives BTN_STATE[0]=0 at +6 with PRESS_PEND unchanged.
3. Bounce: BTN_IN[1] pulsed low 3 cycles, high 1 cycle, repeated 5 times, then held low → no BTN_STATE change during bounce. BTN_STATE[1]=1 exactly 6 cycles after the final stable low.
4. Read/clear: with PRESS_PEND=4'b0101 and BTN_STATE=4'b0001, pulse RD → RD_DATA=8'b0101_0001 next cycle, PRESS_PEND=0 next cycle, IRQ=0 one cycle later.
5. Collision: press on bit 2 reaches its press cycle on the same cycle as RD, with PRESS_PEND=4'b0001 → RD_DATA shows pend 4'b0001, PRESS_PEND afterwards = 4'b0100, IRQ stays 1.
6. Async reset mid-operation: assert RESET_N=0 at cnt=2 with a pend bit set and no clock edge → all outputs 0 immediately. After release, a held button takes the full 6 cycles again.
